// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared constants and state encoding for the SPI flash read engine
//
// Contents:
//   CMD_READ / CMD_FAST_READ  serial NOR read opcodes
//   DUMMY_CYCLES              SCK cycles between address and data for FAST READ
//   flash_rd_state_t          read engine state encoding
package flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam int         DUMMY_CYCLES  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_STALL,
    ST_FINISH
  } flash_rd_state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - divide-by-CLK_DIV SPI mode 0 clock generator with edge strobes
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   run       in   enables toggling; when low SCK is forced low and the divider clears
//   sck       out  SPI clock, idle low
//   sck_rise  out  high in the cycle whose closing clk edge raises sck
//   sck_fall  out  high in the cycle whose closing clk edge lowers sck
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  logic [7:0] cnt;
  logic       toggle;

  assign toggle   = run && (cnt == 8'(CLK_DIV - 1));
  // Strobes are look-ahead: the consumer acts on the same clk edge that moves sck,
  // so a rising-edge sample sees the MISO value present just before SCK goes high.
  assign sck_rise = toggle && !sck;
  assign sck_fall = toggle && sck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (toggle) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - framed SPI NOR read engine delivering 32-bit words on valid/ready
//
// Build option: SPI_FLASH_READER_FAST_READ_EN selects FAST READ (0x0B + 8 dummy clocks);
// otherwise plain READ (0x03) is used. Port list is identical in both builds.
//
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   start                  request pulse, sampled only when idle
//   start_addr[23:0]       first flash byte address (low 2 bits forced to 0)
//   num_words[CNT_W-1:0]   number of words to fetch (0 gives an immediate done)
//   busy, done             transaction in progress / one-cycle completion pulse
//   word_data, word_valid  output word register and its occupied flag
//   word_ready             consumer accept
//   flash_csb, flash_clk   chip select (active low), SCK (mode 0)
//   flash_mosi, flash_miso serial out / in, MSB first
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      start_addr,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_mosi,
  input  logic             flash_miso
);

  import flash_pkg::*;

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] OPCODE   = CMD_FAST_READ;
  localparam bit         USE_DUMMY = 1'b1;
`else
  localparam logic [7:0] OPCODE   = CMD_READ;
  localparam bit         USE_DUMMY = 1'b0;
`endif

  flash_rd_state_t  state, state_next;

  logic             run;
  logic             sck_rise;
  logic             sck_fall;
  logic             accept;
  logic             load;
  logic             last_load;
  logic             done_fin;
  logic             word_full;
  logic             zero_done;
  logic             csb_q;
  logic             mosi_q;
  logic [4:0]       bit_cnt;
  logic [7:0]       fin_cnt;
  logic [31:0]      tx_shift;
  logic [31:0]      rx_shift;
  logic [CNT_W-1:0] remaining;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .sck      (flash_clk),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  assign accept    = (state == ST_IDLE) && start && (num_words != '0);
  // A completed word may move into the output register when it is empty or being drained.
  assign load      = word_full && (!word_valid || word_ready) &&
                     ((state == ST_DATA) || (state == ST_STALL));
  assign last_load = load && (remaining == CNT_W'(1));
  assign done_fin  = (state == ST_FINISH) && csb_q && !word_valid;

  assign done       = done_fin || zero_done;
  assign busy       = (state != ST_IDLE) && !done_fin;
  assign flash_csb  = csb_q;
  assign flash_mosi = mosi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    run        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = ST_CMD;
      end
      ST_CMD: begin
        run = 1'b1;
        if (sck_rise && bit_cnt == 5'd7) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        run = 1'b1;
        if (sck_rise && bit_cnt == 5'd23) state_next = USE_DUMMY ? ST_DUMMY : ST_DATA;
      end
      ST_DUMMY: begin
        run = 1'b1;
        if (sck_rise && bit_cnt == 5'(DUMMY_CYCLES - 1)) state_next = ST_DATA;
      end
      ST_DATA: begin
        run = 1'b1;
        if (word_full) begin
          if (last_load)  state_next = ST_FINISH;
          else if (!load) state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        // Let a high SCK phase finish at its normal length, then park it low.
        run = flash_clk;
        if (last_load)  state_next = ST_FINISH;
        else if (load)  state_next = ST_DATA;
      end
      ST_FINISH: begin
        run = flash_clk;
        if (done_fin) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_q      <= 1'b1;
      mosi_q     <= 1'b0;
      zero_done  <= 1'b0;
      word_full  <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      bit_cnt    <= '0;
      fin_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      remaining  <= '0;
    end else begin
      zero_done <= (state == ST_IDLE) && start && (num_words == '0);

      if (accept) begin
        csb_q     <= 1'b0;
        tx_shift  <= {OPCODE, start_addr[23:2], 2'b00};
        mosi_q    <= OPCODE[7];
        remaining <= num_words;
        bit_cnt   <= '0;
        fin_cnt   <= '0;
        word_full <= 1'b0;
      end

      if (sck_rise) begin
        if (state == ST_DATA) begin
          rx_shift <= {rx_shift[30:0], flash_miso};
          // 5-bit counter wraps to 0 after the 32nd sample of a word.
          bit_cnt  <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) word_full <= 1'b1;
        end else if (state == ST_CMD || state == ST_ADDR || state == ST_DUMMY) begin
          bit_cnt <= (state_next == state) ? bit_cnt + 5'd1 : 5'd0;
        end
      end

      if (sck_fall) begin
        if (state == ST_CMD || state == ST_ADDR) begin
          tx_shift <= {tx_shift[30:0], 1'b0};
          mosi_q   <= tx_shift[30];
        end else begin
          mosi_q <= 1'b0;
        end
      end

      if (load) begin
        // First received byte sits in rx_shift[31:24]; present it as the low byte.
        word_data  <= {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};
        word_valid <= 1'b1;
        word_full  <= 1'b0;
        remaining  <= remaining - CNT_W'(1);
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (state == ST_FINISH && !flash_clk && !csb_q) begin
        if (fin_cnt == 8'(CLK_DIV - 1)) csb_q <= 1'b1;
        else                            fin_cnt <= fin_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - scoreboard bench for spi_flash_reader with a serial NOR flash model
module tb_spi_flash_reader;

  localparam int CLK_DIV = 2;
  localparam int CNT_W   = 16;
`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam int         HDR = 40;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         HDR = 32;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [23:0]      start_addr;
  logic [CNT_W-1:0] num_words;
  logic             busy;
  logic             done;
  logic [31:0]      word_data;
  logic             word_valid;
  logic             word_ready;
  logic             flash_csb;
  logic             flash_clk;
  logic             flash_mosi;
  logic             flash_miso = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          pop_cycles[$];

  int          fl_rises = 0;
  logic [31:0] fl_cmd = '0;
  int          win_rises = 0;
  logic [31:0] win_cmd = '0;
  int          csb_falls = 0;

  spi_flash_reader #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .flash_csb  (flash_csb),
    .flash_clk  (flash_clk),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flash contents: 0x100..0x103 hold EF BE AD DE, everything else is (addr[7:0] + 0x10).
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [1:0] lo;
    lo = a[1:0];
    if (a >= 24'h000100 && a <= 24'h000103) begin
      case (lo)
        2'd0:    return 8'hEF;
        2'd1:    return 8'hBE;
        2'd2:    return 8'hAD;
        default: return 8'hDE;
      endcase
    end
    return a[7:0] + 8'h10;
  endfunction

  always @(negedge flash_csb) begin
    fl_rises = 0;
    fl_cmd   = '0;
    csb_falls++;
  end

  always @(posedge flash_csb) begin
    win_rises = fl_rises;
    win_cmd   = fl_cmd;
  end

  always @(posedge flash_clk) begin
    if (!flash_csb) begin
      if (fl_rises < 32) fl_cmd = {fl_cmd[30:0], flash_mosi};
      fl_rises++;
    end
  end

  always @(negedge flash_clk) begin
    int k;
    logic [7:0] b;
    if (!flash_csb) begin
      if (fl_rises >= HDR) begin
        k = fl_rises - HDR;
        b = flash_byte(fl_cmd[23:0] + 24'(k / 8));
        flash_miso = b[7 - (k % 8)];
      end else begin
        flash_miso = 1'b1;
      end
    end
  end

  logic        mon_hold = 1'b0;
  logic [31:0] hold_data = '0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %h expected none", word_data);
        end else begin
          e = exp_q.pop_front();
          check("word", word_data, e);
        end
        pop_cycles.push_back(cyc);
      end
      if (mon_hold && word_valid) check("word_hold", word_data, hold_data);
      mon_hold  = word_valid && !word_ready;
      hold_data = word_data;
      if (done) check("done_cond", {29'd0, flash_csb, word_valid, busy}, 32'b100);
    end else begin
      mon_hold = 1'b0;
    end
  end

  task automatic do_start(input logic [23:0] a, input logic [CNT_W-1:0] n);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    num_words  = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (word_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ctl"}, {26'd0, flash_csb, flash_clk, flash_mosi, word_valid, busy, done},
          32'b100000);
    check({name, "_data"}, word_data, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int p1, p2, r_mid, falls0;
    bit ok;

    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    num_words  = '0;
    word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Single word with a held-off consumer; also checks first-word latency.
    exp_q.push_back(32'hDEADBEEF);
    do_start(24'h000100, 1);
    p1 = -1;
    p2 = -1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (word_valid) begin
        ok = 1'b1;
        break;
      end
      p2 = p1;
      p1 = fl_rises;
    end
    check("single_valid_seen", {31'd0, ok}, 32'd1);
    check("first_rise_count", 32'(fl_rises), 32'(HDR + 32));
    check("first_valid_lat", {30'd0, p1 == HDR + 32, p2 == HDR + 31}, 32'b11);
    repeat (5) @(negedge clk);
    check("single_busy_hold", {30'd0, busy, done}, 32'b10);
    @(posedge clk);
    #1 word_ready = 1'b1;
    @(posedge clk);
    #1 word_ready = 1'b0;
    wait_done("single");
    check("single_opcode", {24'd0, win_cmd[31:24]}, {24'd0, OPC});
    check("single_addr", {8'd0, win_cmd[23:0]}, 32'h000100);
    check("single_rises", 32'(win_rises), 32'(HDR + 32));
    check("single_q_empty", 32'(exp_q.size()), 32'd0);

    // Burst with consumer always ready: 4 words, one every 32 SCK periods.
    word_ready = 1'b1;
    pop_cycles.delete();
    exp_q.push_back(32'h13121110);
    exp_q.push_back(32'h17161514);
    exp_q.push_back(32'h1B1A1918);
    exp_q.push_back(32'h1F1E1D1C);
    do_start(24'h000200, 4);
    wait_done("burst");
    check("burst_pops", 32'(pop_cycles.size()), 32'd4);
    if (pop_cycles.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("burst_spacing", 32'(pop_cycles[i] - pop_cycles[i-1]), 32'(64 * CLK_DIV));
    end
    check("burst_rises", 32'(win_rises), 32'(HDR + 128));
    check("burst_addr", {8'd0, win_cmd[23:0]}, 32'h000200);
    check("burst_q_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalls 200 cycles after the first word appears.
    word_ready = 1'b0;
    exp_q.push_back(32'h53525150);
    exp_q.push_back(32'h57565554);
    exp_q.push_back(32'h5B5A5958);
    do_start(24'h000040, 3);
    wait_valid("bp");
    repeat (150) @(negedge clk);
    r_mid = fl_rises;
    repeat (50) @(negedge clk);
    check("bp_frozen", 32'(fl_rises), 32'(r_mid));
    check("bp_rises_stalled", 32'(fl_rises), 32'(HDR + 64));
    check("bp_bus_parked", {29'd0, flash_clk, flash_csb, busy}, 32'b001);
    @(posedge clk);
    #1 word_ready = 1'b1;
    wait_done("bp");
    check("bp_rises", 32'(win_rises), 32'(HDR + 96));
    check("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero count: immediate done, no chip select.
    falls0 = csb_falls;
    do_start(24'h000500, 0);
    check("zero_done", {30'd0, done, busy}, 32'b10);
    @(posedge clk);
    #1;
    check("zero_done_pulse", {31'd0, done}, 32'd0);
    check("zero_no_csb", 32'(csb_falls), 32'(falls0));

    // Start while busy is ignored; unaligned address is forced down.
    exp_q.push_back(32'h93929190);
    exp_q.push_back(32'h97969594);
    do_start(24'h000083, 2);
    repeat (20) @(posedge clk);
    do_start(24'h000300, 5);
    wait_done("busy_start");
    check("busy_start_rises", 32'(win_rises), 32'(HDR + 64));
    check("busy_start_addr", {8'd0, win_cmd[23:0]}, 32'h000080);
    repeat (10) @(negedge clk);
    check("busy_start_idle", {30'd0, busy, flash_csb}, 32'b01);
    check("busy_start_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the address phase.
    word_ready = 1'b0;
    do_start(24'h000100, 1);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (fl_rises == 18) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach_addr", {31'd0, ok}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("rst_async");
    @(posedge clk);
    #1 reset = 1'b0;
    word_ready = 1'b1;
    exp_q.push_back(32'hD3D2D1D0);
    do_start(24'h0000C0, 1);
    wait_done("after_rst");
    check("after_rst_addr", {8'd0, win_cmd[23:0]}, 32'h0000C0);
    check("after_rst_q_empty", 32'(exp_q.size()), 32'd0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
